gen_scheduler: RTL and testbench

Sequences Game-of-Life generation updates against the VGA frame cadence. It replaces free-running generation triggering with frame-locked pacing: run/pause, single-step and a speed divider counted in frames. It issues a one-cycle go to the next-field iterator only when the iterator and config loader permit, tracks the in-flight generation to completion, and maintains a generation counter. It sits between the filtered-button command inputs, the VGA timing block (frame-start pulse) and the next-field iterator.

---
 rtl/gen_scheduler.sv | 145 ++++++++++++++
 tb/tb_gen_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_scheduler.sv
// Frame-locked generation scheduler for the Game-of-Life iterator: run/pause, single-step,
// speed divider counted in VGA frames, go/done handshake tracking and a generation counter.
module gen_scheduler #(
  parameter int unsigned MAX_SPEED     = 7,
  parameter int unsigned DEFAULT_SPEED = 3,
  parameter int unsigned GEN_CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_cmd_toggle_pause,
  input  logic                           i_cmd_step,
  input  logic                           i_cmd_speed_up,
  input  logic                           i_cmd_speed_down,
  input  logic                           i_frame_start,
  input  logic                           i_NFI_allowed,
  input  logic                           i_NFI_is_simulating,
  input  logic                           i_cfg_loaded,
  output logic                           o_go,
  output logic                           o_paused,
  output logic [$clog2(MAX_SPEED+1)-1:0] o_speed,
  output logic [GEN_CNT_W-1:0]           o_gen_cnt,
  output logic                           o_gen_done
);

  localparam int unsigned SW = $clog2(MAX_SPEED + 1);
  // Frame counter must reach 2^MAX_SPEED - 1.
  localparam int unsigned FW = (MAX_SPEED > 0) ? MAX_SPEED : 1;

  typedef enum logic [2:0] {
    StPaused,
    StWaitFrame,
    StWaitAllowed,
    StWaitStart,
    StWaitDone
  } state_e;

  state_e               state_q, state_d;
  logic                 paused_q, paused_d;
  logic [SW-1:0]        speed_q, speed_d;
  logic [FW-1:0]        frame_cnt_q, frame_cnt_d;
  logic                 step_q, step_d;
  logic                 go_q, go_d;
  logic [GEN_CNT_W-1:0] gen_cnt_q, gen_cnt_d;
  logic                 gen_done_q, gen_done_d;
  logic [FW-1:0]        period_m1;

  // 2^speed - 1 as a low-bit mask; no divider needed.
  assign period_m1 = ~({FW{1'b1}} << speed_q);
  assign paused_d  = paused_q ^ i_cmd_toggle_pause;

  always_comb begin
    speed_d = speed_q;
    if (i_cmd_speed_up && !i_cmd_speed_down && speed_q != '0) begin
      speed_d = speed_q - SW'(1);
    end else if (i_cmd_speed_down && !i_cmd_speed_up && speed_q != SW'(MAX_SPEED)) begin
      speed_d = speed_q + SW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    step_d      = step_q;
    go_d        = 1'b0;
    gen_cnt_d   = gen_cnt_q;
    gen_done_d  = 1'b0;

    unique case (state_q)
      StPaused: begin
        if (!paused_q) begin
          state_d     = StWaitFrame;
          frame_cnt_d = '0;
          step_d      = 1'b0;
        end else if (i_cmd_step && !i_cmd_toggle_pause) begin
          state_d = StWaitAllowed;
          step_d  = 1'b1;
        end
      end
      StWaitFrame: begin
        if (paused_q) begin
          state_d = StPaused;
        end else if (i_frame_start) begin
          if (frame_cnt_q == period_m1) begin
            frame_cnt_d = '0;
            step_d      = 1'b0;
            state_d     = StWaitAllowed;
          end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
          end
        end
      end
      StWaitAllowed: begin
        // A pause arriving here does not cancel the pending go.
        if (i_NFI_allowed && !i_NFI_is_simulating) begin
          go_d    = 1'b1;
          state_d = StWaitStart;
        end
      end
      StWaitStart: begin
        if (i_NFI_is_simulating) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!i_NFI_is_simulating) begin
          gen_cnt_d  = gen_cnt_q + GEN_CNT_W'(1);
          gen_done_d = 1'b1;
          state_d    = (paused_q || step_q) ? StPaused : StWaitFrame;
        end
      end
      default: state_d = StPaused;
    endcase

    // Any real level change restarts the frame count; saturated no-ops leave it alone.
    if (speed_d != speed_q) frame_cnt_d = '0;
    if (i_cfg_loaded) gen_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPaused;
      paused_q    <= 1'b1;
      speed_q     <= SW'(DEFAULT_SPEED);
      frame_cnt_q <= '0;
      step_q      <= 1'b0;
      go_q        <= 1'b0;
      gen_cnt_q   <= '0;
      gen_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      paused_q    <= paused_d;
      speed_q     <= speed_d;
      frame_cnt_q <= frame_cnt_d;
      step_q      <= step_d;
      go_q        <= go_d;
      gen_cnt_q   <= gen_cnt_d;
      gen_done_q  <= gen_done_d;
    end
  end

  assign o_go       = go_q;
  assign o_paused   = paused_q;
  assign o_speed    = speed_q;
  assign o_gen_cnt  = gen_cnt_q;
  assign o_gen_done = gen_done_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// Bench for gen_scheduler: behavioural iterator model plus frame-count arithmetic reference.
module tb_gen_scheduler;

  localparam int unsigned MaxSpeed = 7;
  localparam int unsigned DefSpeed = 3;
  localparam int unsigned CntW     = 4;
  localparam int unsigned SpW      = $clog2(MaxSpeed + 1);

  localparam int CmdToggle = 0;
  localparam int CmdStep   = 1;
  localparam int CmdUp     = 2;
  localparam int CmdDown   = 3;
  localparam int CmdFrame  = 4;
  localparam int CmdCfg    = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            toggle = 1'b0, step = 1'b0, up = 1'b0, down = 1'b0, frame_start = 1'b0;
  logic            nfi_allowed, cfg_loaded;
  logic            nfi_sim = 1'b0, pending = 1'b0;
  logic            allow_en = 1'b1, cfg_task = 1'b0, cfg_auto = 1'b0, cfg_on_done = 1'b0;
  logic            go, paused, gen_done;
  logic [SpW-1:0]  speed;
  logic [CntW-1:0] gen_cnt;

  int busy_len = 10, busy_left = 0;
  int go_cnt = 0, done_cnt = 0, go_bad = 0, done_wide = 0;
  logic prev_done = 1'b0;
  int checks = 0, passes = 0;
  int m_speed = DefSpeed, m_gen = 0;

  always #5 clk = ~clk;

  assign nfi_allowed = allow_en && !nfi_sim && !pending;
  assign cfg_loaded  = cfg_task | cfg_auto;

  gen_scheduler #(
    .MAX_SPEED    (MaxSpeed),
    .DEFAULT_SPEED(DefSpeed),
    .GEN_CNT_W    (CntW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_cmd_toggle_pause (toggle),
    .i_cmd_step         (step),
    .i_cmd_speed_up     (up),
    .i_cmd_speed_down   (down),
    .i_frame_start      (frame_start),
    .i_NFI_allowed      (nfi_allowed),
    .i_NFI_is_simulating(nfi_sim),
    .i_cfg_loaded       (cfg_loaded),
    .o_go               (go),
    .o_paused           (paused),
    .o_speed            (speed),
    .o_gen_cnt          (gen_cnt),
    .o_gen_done         (gen_done)
  );

  // Iterator model (busy for busy_len cycles, starting the cycle after go) and output monitor.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      nfi_sim   <= 1'b0;
      busy_left <= 0;
      cfg_auto  <= 1'b0;
      prev_done <= 1'b0;
    end else begin
      if (go) begin
        go_cnt <= go_cnt + 1;
        if (nfi_sim || !nfi_allowed) go_bad <= go_bad + 1;
      end
      if (gen_done) begin
        done_cnt <= done_cnt + 1;
        if (prev_done) done_wide <= done_wide + 1;
      end
      prev_done <= gen_done;
      cfg_auto  <= 1'b0;
      if (pending) begin
        nfi_sim   <= 1'b1;
        busy_left <= busy_len;
      end else if (nfi_sim) begin
        busy_left <= busy_left - 1;
        if (busy_left == 1) begin
          nfi_sim  <= 1'b0;
          cfg_auto <= cfg_on_done;
        end
      end
      pending <= go;
    end
  end

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      CmdToggle: toggle = 1'b1;
      CmdStep:   step = 1'b1;
      CmdUp:     up = 1'b1;
      CmdDown:   down = 1'b1;
      CmdFrame:  frame_start = 1'b1;
      default:   cfg_task = 1'b1;
    endcase
    @(negedge clk);
    toggle = 1'b0; step = 1'b0; up = 1'b0; down = 1'b0; frame_start = 1'b0; cfg_task = 1'b0;
  endtask

  task automatic frame(input int gap);
    pulse(CmdFrame);
    repeat (gap) @(negedge clk);
  endtask

  // Reference speed model: saturating at both ends.
  task automatic set_speed(input int target);
    for (int i = 0; i < 16 && m_speed != target; i++) begin
      if (m_speed > target) begin
        pulse(CmdUp);
        m_speed = m_speed - 1;
      end else begin
        pulse(CmdDown);
        m_speed = m_speed + 1;
      end
    end
  endtask

  task automatic wait_sim(input string name);
    int n = 0;
    while (!nfi_sim && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!nfi_sim) $display("FAIL %s: iterator never started (go count %0d)", name, go_cnt);
    else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (paused !== 1'b1) $display("FAIL rst_paused: got %b want 1", paused); else passes++;
    if (speed !== SpW'(DefSpeed)) $display("FAIL rst_speed: got %0d want %0d", speed, DefSpeed);
    else passes++;
    if (go !== 1'b0) $display("FAIL rst_go: got %b want 0", go); else passes++;
    if (gen_cnt !== '0) $display("FAIL rst_gen_cnt: got %0d want 0", gen_cnt); else passes++;
    if (gen_done !== 1'b0) $display("FAIL rst_gen_done: got %b want 0", gen_done); else passes++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) frame(10);
    checks += 3;
    if (go_cnt !== 0) $display("FAIL paused_no_go: got %0d gos want 0", go_cnt); else passes++;
    if (paused !== 1'b1) $display("FAIL paused_hold: got %b want 1", paused); else passes++;
    if (gen_cnt !== '0) $display("FAIL paused_cnt: got %0d want 0", gen_cnt); else passes++;
  endtask

  task automatic test_run_fast();
    int g0, d0;
    allow_en = 1'b1;
    busy_len = 10;
    set_speed(0);
    pulse(CmdToggle);
    repeat (3) @(negedge clk);
    g0 = go_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) frame(30);
    m_gen = (m_gen + 4) % (1 << CntW);
    checks += 5;
    if (go_cnt - g0 != 4) $display("FAIL fast_go: got %0d want 4", go_cnt - g0); else passes++;
    if (done_cnt - d0 != 4) $display("FAIL fast_done: got %0d want 4", done_cnt - d0);
    else passes++;
    if (gen_cnt !== CntW'(m_gen)) $display("FAIL fast_cnt: got %0d want %0d", gen_cnt, m_gen);
    else passes++;
    if (done_wide != 0) $display("FAIL done_width: got %0d wide pulses want 0", done_wide);
    else passes++;
    if (go_bad != 0) $display("FAIL go_guard: got %0d illegal gos want 0", go_bad); else passes++;
    pulse(CmdToggle);
    repeat (5) @(negedge clk);
    checks++;
    if (paused !== 1'b1) $display("FAIL fast_repause: got %b want 1", paused); else passes++;
  endtask

  task automatic test_random_run();
    for (int it = 0; it < 4; it++) begin
      int s, n, g0, exp_g;
      s = int'($urandom_range(0, 2));
      n = int'($urandom_range(3, 10));
      busy_len = int'($urandom_range(2, 12));
      set_speed(s);
      checks++;
      if (speed !== SpW'(m_speed)) $display("FAIL rnd_speed: got %0d want %0d", speed, m_speed);
      else passes++;
      pulse(CmdToggle);
      repeat (3) @(negedge clk);
      g0 = go_cnt;
      for (int f = 0; f < n; f++) frame(busy_len + 15 + int'($urandom_range(0, 5)));
      exp_g = n / (1 << s);
      m_gen = (m_gen + exp_g) % (1 << CntW);
      pulse(CmdToggle);
      repeat (busy_len + 20) @(negedge clk);
      checks += 3;
      if (go_cnt - g0 != exp_g)
        $display("FAIL rnd_go: speed %0d frames %0d got %0d want %0d", s, n, go_cnt - g0, exp_g);
      else passes++;
      if (gen_cnt !== CntW'(m_gen)) $display("FAIL rnd_cnt: got %0d want %0d", gen_cnt, m_gen);
      else passes++;
      if (paused !== 1'b1) $display("FAIL rnd_paused: got %b want 1", paused); else passes++;
    end
  endtask

  task automatic test_speed_change();
    int g0;
    busy_len = 6;
    set_speed(2);
    pulse(CmdToggle);
    repeat (3) @(negedge clk);
    g0 = go_cnt;
    for (int i = 0; i < 3; i++) frame(25);
    checks++;
    if (go_cnt - g0 != 0) $display("FAIL spd_early: got %0d want 0", go_cnt - g0); else passes++;
    frame(25);
    checks++;
    if (go_cnt - g0 != 1) $display("FAIL spd_4th: got %0d want 1", go_cnt - g0); else passes++;
    frame(25);
    frame(25);
    pulse(CmdUp);
    m_speed = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (speed !== SpW'(1)) $display("FAIL spd_up: got %0d want 1", speed); else passes++;
    frame(25);
    checks++;
    if (go_cnt - g0 != 1) $display("FAIL spd_cleared: got %0d want 1", go_cnt - g0);
    else passes++;
    frame(25);
    checks++;
    if (go_cnt - g0 != 2) $display("FAIL spd_new_period: got %0d want 2", go_cnt - g0);
    else passes++;
    m_gen = (m_gen + 2) % (1 << CntW);
    pulse(CmdToggle);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_step();
    int g0, d0;
    busy_len = 8;
    allow_en = 1'b0;
    g0 = go_cnt;
    d0 = done_cnt;
    pulse(CmdStep);
    repeat (20) @(negedge clk);
    checks++;
    if (go_cnt - g0 != 0) $display("FAIL step_blocked: got %0d want 0", go_cnt - g0);
    else passes++;
    allow_en = 1'b1;
    wait_sim("step_start");
    pulse(CmdStep);
    repeat (40) @(negedge clk);
    m_gen = (m_gen + 1) % (1 << CntW);
    checks += 4;
    if (go_cnt - g0 != 1) $display("FAIL step_go: got %0d want 1", go_cnt - g0); else passes++;
    if (done_cnt - d0 != 1) $display("FAIL step_done: got %0d want 1", done_cnt - d0);
    else passes++;
    if (gen_cnt !== CntW'(m_gen)) $display("FAIL step_cnt: got %0d want %0d", gen_cnt, m_gen);
    else passes++;
    if (paused !== 1'b1) $display("FAIL step_paused: got %b want 1", paused); else passes++;
  endtask

  task automatic test_pause_inflight();
    int g0;
    busy_len = 15;
    set_speed(0);
    pulse(CmdToggle);
    repeat (3) @(negedge clk);
    g0 = go_cnt;
    frame(0);
    wait_sim("inflight_start");
    pulse(CmdToggle);
    repeat (40) @(negedge clk);
    m_gen = (m_gen + 1) % (1 << CntW);
    checks += 2;
    if (gen_cnt !== CntW'(m_gen)) $display("FAIL inflight_cnt: got %0d want %0d", gen_cnt, m_gen);
    else passes++;
    if (paused !== 1'b1) $display("FAIL inflight_paused: got %b want 1", paused); else passes++;
    frame(10);
    frame(10);
    checks++;
    if (go_cnt - g0 != 1) $display("FAIL inflight_stop: got %0d want 1", go_cnt - g0);
    else passes++;
    for (int i = 0; i < 10; i++) begin
      pulse(CmdDown);
      if (m_speed < MaxSpeed) m_speed++;
    end
    checks++;
    if (speed !== SpW'(m_speed)) $display("FAIL spd_sat: got %0d want %0d", speed, m_speed);
    else passes++;
    @(negedge clk);
    up = 1'b1;
    down = 1'b1;
    @(negedge clk);
    up = 1'b0;
    down = 1'b0;
    @(negedge clk);
    checks++;
    if (speed !== SpW'(m_speed)) $display("FAIL spd_cancel: got %0d want %0d", speed, m_speed);
    else passes++;
  endtask

  task automatic test_wrap_cfg();
    int d0;
    pulse(CmdCfg);
    m_gen = 0;
    @(negedge clk);
    checks++;
    if (gen_cnt !== '0) $display("FAIL cfg_clear: got %0d want 0", gen_cnt); else passes++;
    busy_len = 3;
    set_speed(0);
    pulse(CmdToggle);
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) begin
      frame(20);
      if (i == 4) begin
        checks++;
        if (gen_cnt !== CntW'(5)) $display("FAIL wrap_mid: got %0d want 5", gen_cnt);
        else passes++;
      end
    end
    checks += 2;
    if (done_cnt - d0 != 16) $display("FAIL wrap_done: got %0d want 16", done_cnt - d0);
    else passes++;
    if (gen_cnt !== '0) $display("FAIL wrap_cnt: got %0d want 0", gen_cnt); else passes++;
    for (int i = 0; i < 3; i++) frame(20);
    d0 = done_cnt;
    cfg_on_done = 1'b1;
    frame(20);
    cfg_on_done = 1'b0;
    checks += 2;
    if (done_cnt - d0 != 1) $display("FAIL cfg_done_pulse: got %0d want 1", done_cnt - d0);
    else passes++;
    if (gen_cnt !== '0) $display("FAIL cfg_coincide: got %0d want 0", gen_cnt); else passes++;
    busy_len = 30;
    frame(0);
    wait_sim("rst_mid_start");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_speed = DefSpeed;
    checks += 5;
    if (paused !== 1'b1) $display("FAIL arst_paused: got %b want 1", paused); else passes++;
    if (speed !== SpW'(m_speed)) $display("FAIL arst_speed: got %0d want %0d", speed, m_speed);
    else passes++;
    if (go !== 1'b0) $display("FAIL arst_go: got %b want 0", go); else passes++;
    if (gen_cnt !== '0) $display("FAIL arst_cnt: got %0d want 0", gen_cnt); else passes++;
    if (gen_done !== 1'b0) $display("FAIL arst_done: got %b want 0", gen_done); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_run_fast();
    test_random_run();
    test_speed_change();
    test_step();
    test_pause_inflight();
    test_wrap_cfg();
    checks++;
    if (go_bad != 0) $display("FAIL go_guard_final: got %0d illegal gos want 0", go_bad);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
